// File: rtl/alu_sched_pkg.sv
// Shared opcode map, scheduler state encoding and opcode legality check
// for the round-robin ALU scheduler.
package alu_sched_pkg;

    localparam logic [3:0] OP_DIV  = 4'd0;
    localparam logic [3:0] OP_SRA  = 4'd1;
    localparam logic [3:0] OP_ROR  = 4'd2;
    localparam logic [3:0] OP_ROL  = 4'd3;
    localparam logic [3:0] OP_SGT  = 4'd4;
    localparam logic [3:0] OP_OR   = 4'd5;
    localparam logic [3:0] OP_AND  = 4'd6;
    localparam logic [3:0] OP_MAX  = 4'd7;
    localparam logic [3:0] OP_SLT  = 4'd8;
    localparam logic [3:0] OP_SGE  = 4'd9;
    localparam logic [3:0] OP_NAND = 4'd10;
    localparam logic [3:0] OP_SLL  = 4'd11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXEC    = 2'd1,
        ST_ILLEGAL = 2'd2,
        ST_RESP    = 2'd3
    } sched_state_e;

    // The compare ops have no defined ALU result, and 12..15 are unassigned.
    function automatic logic is_supported(input logic [31:0] op);
        logic ok;
        ok = 1'b1;
        if (op == 32'(OP_SGT) || op == 32'(OP_SLT) || op == 32'(OP_SGE) || op > 32'(OP_SLL))
            ok = 1'b0;
        return ok;
    endfunction

endpackage

// File: rtl/alu_rr_scheduler_if.sv
// Request/response bundle between client blocks and the ALU scheduler.
interface alu_rr_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 16,
    parameter int OPW     = 4,
    parameter int SHW     = 5,
    parameter int IDW     = 2
);
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*OPW-1:0]   req_opcode;
    logic [NUM_REQ*WIDTH-1:0] req_in1;
    logic [NUM_REQ*WIDTH-1:0] req_in2;
    logic [NUM_REQ*SHW-1:0]   req_shift;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [IDW-1:0]           rsp_id;
    logic [WIDTH-1:0]         rsp_result;
    logic                     rsp_zero;
    logic                     rsp_sign;
    logic                     rsp_err;

    modport master (
        output req_valid, req_opcode, req_in1, req_in2, req_shift, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_sign, rsp_err
    );

    modport slave (
        input  req_valid, req_opcode, req_in1, req_in2, req_shift, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_sign, rsp_err
    );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above ptr_i,
// wrapping past NUM_REQ-1 back to 0.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDW-1:0]     ptr_i,
    input  logic               en_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDW-1:0]     idx_o
);
    logic found;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (en_i && !found && req_i[j] && (j == ((int'(ptr_i) + k) % NUM_REQ))) begin
                    found    = 1'b1;
                    gnt_o[j] = 1'b1;
                    idx_o    = IDW'(j);
                end
            end
        end
    end
endmodule

// File: rtl/alu_rr_scheduler.sv
// Shares one external combinational ALU among NUM_REQ requesters with
// round-robin arbitration and a single operation in flight.
module alu_rr_scheduler
    import alu_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 16,
    parameter int OPW     = 4,
    parameter int SHW     = 5,
    parameter int IDW     = 2
) (
    input  logic               clk,
    input  logic               rst,
    alu_rr_scheduler_if.slave  bus,
    output logic [OPW-1:0]     alu_opcode,
    output logic [WIDTH-1:0]   alu_input1,
    output logic [WIDTH-1:0]   alu_input2,
    output logic [SHW-1:0]     alu_shift,
    input  logic [WIDTH-1:0]   alu_result,
    input  logic               alu_zero,
    input  logic               alu_sign
);
    sched_state_e       state_q, state_d;
    logic [IDW-1:0]     ptr_q, ptr_d;
    logic [NUM_REQ-1:0] gnt;
    logic [IDW-1:0]     gidx;
    logic               arb_en;

    logic [OPW-1:0]     op_q, op_d;
    logic [WIDTH-1:0]   in1_q, in1_d, in2_q, in2_d;
    logic [SHW-1:0]     sh_q, sh_d;
    logic               vld_q, vld_d, zero_q, zero_d, sign_q, sign_d, err_q, err_d;
    logic [IDW-1:0]     id_q, id_d;
    logic [WIDTH-1:0]   res_q, res_d;

    logic [OPW-1:0]     op_a  [NUM_REQ];
    logic [WIDTH-1:0]   in1_a [NUM_REQ];
    logic [WIDTH-1:0]   in2_a [NUM_REQ];
    logic [SHW-1:0]     sh_a  [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign op_a[g]  = bus.req_opcode[g*OPW +: OPW];
        assign in1_a[g] = bus.req_in1[g*WIDTH +: WIDTH];
        assign in2_a[g] = bus.req_in2[g*WIDTH +: WIDTH];
        assign sh_a[g]  = bus.req_shift[g*SHW +: SHW];
    end

    // Grants are offered only in IDLE, and never while reset is held.
    assign arb_en = (state_q == ST_IDLE) && !rst;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .IDW(IDW)) u_arb (
        .req_i (bus.req_valid),
        .ptr_i (ptr_q),
        .en_i  (arb_en),
        .gnt_o (gnt),
        .idx_o (gidx)
    );

    assign bus.req_ready  = gnt;
    assign bus.rsp_valid  = vld_q;
    assign bus.rsp_id     = id_q;
    assign bus.rsp_result = res_q;
    assign bus.rsp_zero   = zero_q;
    assign bus.rsp_sign   = sign_q;
    assign bus.rsp_err    = err_q;
    assign alu_opcode     = op_q;
    assign alu_input1     = in1_q;
    assign alu_input2     = in2_q;
    assign alu_shift      = sh_q;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        op_d    = op_q;
        in1_d   = in1_q;
        in2_d   = in2_q;
        sh_d    = sh_q;
        vld_d   = vld_q;
        id_d    = id_q;
        res_d   = res_q;
        zero_d  = zero_q;
        sign_d  = sign_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (|gnt) begin
                    op_d    = op_a[gidx];
                    in1_d   = in1_a[gidx];
                    in2_d   = in2_a[gidx];
                    sh_d    = sh_a[gidx];
                    id_d    = gidx;
                    ptr_d   = (int'(gidx) == NUM_REQ - 1) ? '0 : gidx + 1'b1;
                    state_d = is_supported(32'(op_a[gidx])) ? ST_EXEC : ST_ILLEGAL;
                end
            end
            ST_EXEC: begin
                res_d   = alu_result;
                zero_d  = alu_zero;
                sign_d  = alu_sign;
                err_d   = 1'b0;
                vld_d   = 1'b1;
                state_d = ST_RESP;
            end
            ST_ILLEGAL: begin
                res_d   = '0;
                zero_d  = 1'b1;
                sign_d  = 1'b0;
                err_d   = 1'b1;
                vld_d   = 1'b1;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    vld_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            op_q    <= '0;
            in1_q   <= '0;
            in2_q   <= '0;
            sh_q    <= '0;
            vld_q   <= 1'b0;
            id_q    <= '0;
            res_q   <= '0;
            zero_q  <= 1'b0;
            sign_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            op_q    <= op_d;
            in1_q   <= in1_d;
            in2_q   <= in2_d;
            sh_q    <= sh_d;
            vld_q   <= vld_d;
            id_q    <= id_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
            sign_q  <= sign_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Directed bench for alu_rr_scheduler with a behavioural stand-in for the
// shared ALU (unsupported opcodes return a poison value).
module tb_alu_rr_scheduler;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  alu_opcode;
    logic [15:0] alu_input1, alu_input2, alu_result;
    logic [4:0]  alu_shift;
    logic        alu_zero, alu_sign;
    int          n_vec = 0;
    int          n_err = 0;

    alu_rr_scheduler_if #(.NUM_REQ(4), .WIDTH(16), .OPW(4), .SHW(5), .IDW(2)) bus ();

    alu_rr_scheduler #(.NUM_REQ(4), .WIDTH(16), .OPW(4), .SHW(5), .IDW(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .alu_opcode (alu_opcode),
        .alu_input1 (alu_input1),
        .alu_input2 (alu_input2),
        .alu_shift  (alu_shift),
        .alu_result (alu_result),
        .alu_zero   (alu_zero),
        .alu_sign   (alu_sign)
    );

    always #5 clk = ~clk;

    always_comb begin
        logic signed [15:0] s;
        s = alu_input1;
        case (alu_opcode)
            4'd0:    alu_result = (alu_input2 == 16'd0) ? 16'd0 : alu_input1 / alu_input2;
            4'd1:    alu_result = 16'(s >>> alu_shift);
            4'd5:    alu_result = alu_input1 | alu_input2;
            4'd6:    alu_result = alu_input1 & alu_input2;
            4'd11:   alu_result = 16'(alu_input1 << alu_shift);
            default: alu_result = 16'hDEAD;
        endcase
        alu_zero = (alu_result == 16'd0);
        alu_sign = alu_result[15];
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [3:0] op, input logic [15:0] a,
                           input logic [15:0] b, input logic [4:0] sh);
        bus.req_valid[i]          = 1'b1;
        bus.req_opcode[i*4 +: 4]  = op;
        bus.req_in1[i*16 +: 16]   = a;
        bus.req_in2[i*16 +: 16]   = b;
        bus.req_shift[i*5 +: 5]   = sh;
    endtask

    task automatic clr_req(input int i);
        bus.req_valid[i] = 1'b0;
    endtask

    task automatic check_rsp(input string tag, input logic [1:0] id, input logic [15:0] res,
                             input logic z, input logic sg, input logic er);
        check_val({tag, "_valid"}, 32'(bus.rsp_valid), 32'd1);
        check_val({tag, "_id"}, 32'(bus.rsp_id), 32'(id));
        check_val({tag, "_result"}, 32'(bus.rsp_result), 32'(res));
        check_val({tag, "_zero"}, 32'(bus.rsp_zero), 32'(z));
        check_val({tag, "_sign"}, 32'(bus.rsp_sign), 32'(sg));
        check_val({tag, "_err"}, 32'(bus.rsp_err), 32'(er));
    endtask

    // Issue one op from requester i (assumed to win), then land on the response cycle.
    task automatic issue(input string tag, input int i, input logic [3:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic [4:0] sh);
        set_req(i, op, a, b, sh);
        @(negedge clk);
        check_val({tag, "_grant"}, 32'(bus.req_ready), 32'(1 << i));
        cyc();
        clr_req(i);
        @(negedge clk);
        check_val({tag, "_exec_valid"}, 32'(bus.rsp_valid), 32'd0);
        cyc();
        @(negedge clk);
    endtask

    initial begin
        rst            = 1'b1;
        bus.req_valid  = '0;
        bus.req_opcode = '0;
        bus.req_in1    = '0;
        bus.req_in2    = '0;
        bus.req_shift  = '0;
        bus.rsp_ready  = 1'b0;
        cyc();
        cyc();

        // Reset state, with a request already pending
        set_req(0, 4'd5, 16'h00F0, 16'h0F00, 5'd0);
        @(negedge clk);
        check_val("rst_ready", 32'(bus.req_ready), 32'd0);
        check_val("rst_valid", 32'(bus.rsp_valid), 32'd0);
        check_val("rst_alu_op", 32'(alu_opcode), 32'd0);
        check_val("rst_alu_in1", 32'(alu_input1), 32'd0);
        check_val("rst_err", 32'(bus.rsp_err), 32'd0);
        cyc();
        rst = 1'b0;

        // Single OR from requester 0
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        check_val("or_grant", 32'(bus.req_ready), 32'd1);
        cyc();
        clr_req(0);
        @(negedge clk);
        check_val("or_alu_op", 32'(alu_opcode), 32'd5);
        check_val("or_alu_in1", 32'(alu_input1), 32'h00F0);
        check_val("or_alu_in2", 32'(alu_input2), 32'h0F00);
        check_val("or_exec_valid", 32'(bus.rsp_valid), 32'd0);
        check_val("or_exec_ready", 32'(bus.req_ready), 32'd0);
        cyc();
        @(negedge clk);
        check_rsp("or", 2'd0, 16'h0FF0, 1'b0, 1'b0, 1'b0);
        cyc();
        @(negedge clk);
        check_val("or_done_valid", 32'(bus.rsp_valid), 32'd0);

        // All four requesters continuously valid, fresh pointer
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) set_req(k, 4'd6, 16'hFFFF, 16'(k), 5'd0);
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            check_val($sformatf("rr%0d_grant", n), 32'(bus.req_ready), 32'(1 << (n % 4)));
            cyc();
            @(negedge clk);
            check_val($sformatf("rr%0d_exec_valid", n), 32'(bus.rsp_valid), 32'd0);
            cyc();
            @(negedge clk);
            check_rsp($sformatf("rr%0d", n), 2'(n % 4), 16'(n % 4), (n % 4) == 0, 1'b0, 1'b0);
            check_val($sformatf("rr%0d_resp_ready", n), 32'(bus.req_ready), 32'd0);
            cyc();
        end
        for (int k = 0; k < 4; k++) clr_req(k);

        // Backpressure: SLL from requester 1 while requester 3 waits
        bus.rsp_ready = 1'b0;
        set_req(3, 4'd6, 16'hFFFF, 16'h00FF, 5'd0);
        issue("sll", 1, 4'd11, 16'h0001, 16'h0000, 5'd15);
        for (int h = 0; h < 5; h++) begin
            check_rsp($sformatf("bp%0d", h), 2'd1, 16'h8000, 1'b0, 1'b1, 1'b0);
            check_val($sformatf("bp%0d_ready", h), 32'(bus.req_ready), 32'd0);
            cyc();
            @(negedge clk);
        end
        bus.rsp_ready = 1'b1;
        check_val("bp_accept_ready", 32'(bus.req_ready), 32'd0);
        cyc();
        @(negedge clk);
        check_val("bp_after_valid", 32'(bus.rsp_valid), 32'd0);
        check_val("bp_after_grant", 32'(bus.req_ready), 32'b1000);
        clr_req(3);
        cyc();

        // Unsupported opcodes from requester 2
        issue("ill4", 2, 4'd4, 16'h1234, 16'h5678, 5'd3);
        check_rsp("ill4", 2'd2, 16'h0000, 1'b1, 1'b0, 1'b1);
        cyc();
        issue("ill13", 2, 4'd13, 16'h1234, 16'h5678, 5'd3);
        check_rsp("ill13", 2'd2, 16'h0000, 1'b1, 1'b0, 1'b1);
        cyc();

        // Divide by zero, then arithmetic shift right
        issue("div0", 0, 4'd0, 16'h1234, 16'h0000, 5'd0);
        check_rsp("div0", 2'd0, 16'h0000, 1'b1, 1'b0, 1'b0);
        cyc();
        issue("sra", 0, 4'd1, 16'h8000, 16'h0000, 5'd4);
        check_rsp("sra", 2'd0, 16'hF800, 1'b0, 1'b1, 1'b0);
        cyc();

        // Reset during EXEC discards the operation and rewinds the pointer
        set_req(1, 4'd5, 16'h00AA, 16'h5500, 5'd0);
        @(negedge clk);
        check_val("rx_grant", 32'(bus.req_ready), 32'b0010);
        cyc();
        clr_req(1);
        rst = 1'b1;
        @(negedge clk);
        check_val("rx_rst_ready", 32'(bus.req_ready), 32'd0);
        cyc();
        rst = 1'b0;
        set_req(0, 4'd6, 16'h00FF, 16'h0F0F, 5'd0);
        set_req(1, 4'd5, 16'h0001, 16'h0002, 5'd0);
        @(negedge clk);
        check_val("rx_valid", 32'(bus.rsp_valid), 32'd0);
        check_val("rx_alu_op", 32'(alu_opcode), 32'd0);
        check_val("rx_grant0", 32'(bus.req_ready), 32'b0001);
        cyc();
        clr_req(0);
        @(negedge clk);
        check_val("rx_exec_valid", 32'(bus.rsp_valid), 32'd0);
        cyc();
        @(negedge clk);
        check_rsp("rx", 2'd0, 16'h000F, 1'b0, 1'b0, 1'b0);
        cyc();
        @(negedge clk);
        check_val("rx_grant1", 32'(bus.req_ready), 32'b0010);
        clr_req(1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/alu_rr_scheduler.md
Name: alu_rr_scheduler

Overview:
- Shares one 16-bit combinational ALU instance among NUM_REQ requesters.
- Round-robin arbitration; one operation in flight at a time.
- Registers the operands into the ALU, captures result/zero/sign, and returns a tagged response over a valid/ready channel.
- Sits between client blocks (e.g. address generators, test sequencers) and the shared ALU.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 16, ALU datapath width.
- OPW, 4, opcode width.
- SHW, 5, shift-amount width.
- IDW, 2, response tag width; must be >= clog2(NUM_REQ).

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high.
- req_opcode  in  NUM_REQ*OPW  packed opcodes; requester i at slice i.
- req_in1  in  NUM_REQ*WIDTH  packed operand 1.
- req_in2  in  NUM_REQ*WIDTH  packed operand 2.
- req_shift  in  NUM_REQ*SHW  packed shift amounts.
- alu_opcode  out  OPW  registered opcode to ALU.
- alu_input1  out  WIDTH  registered operand 1 to ALU.
- alu_input2  out  WIDTH  registered operand 2 to ALU.
- alu_shift  out  SHW  registered shift amount to ALU.
- alu_result  in  WIDTH  ALU result.
- alu_zero  in  1  ALU zero flag.
- alu_sign  in  1  ALU sign flag.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_id  out  IDW  index of the requester served.
- rsp_result  out  WIDTH  captured result.
- rsp_zero  out  1  captured zero flag.
- rsp_sign  out  1  captured sign flag.
- rsp_err  out  1  opcode was not issued (unsupported).

Behaviour:
- Reset: all of the following clear synchronously while rst=1, and rst overrides all other activity.
  - State = IDLE; rr pointer = 0.
  - alu_opcode/alu_input1/alu_input2/alu_shift = 0.
  - rsp_valid/rsp_id/rsp_result/rsp_zero/rsp_sign/rsp_err = 0.
  - req_ready = 0.
- Reset mid-operation discards the in-flight operation; no response is produced.
- State IDLE:
  - Grant = first i with req_valid[i]=1, searching from the pointer upward with wrap (NUM_REQ-1 -> 0).
  - req_ready[grant] = 1 combinationally; all other bits 0; no grant when no request is valid.
  - Handshake on req_valid&req_ready at edge N:
    - Latch opcode/operands/shift into the alu_* registers, and the id.
    - Pointer = (grant+1) mod NUM_REQ.
    - Next state EXEC, or ILLEGAL if the opcode is unsupported.
- State EXEC (cycle N+1):
  - ALU settles combinationally.
  - At edge N+1: capture alu_result/alu_zero/alu_sign, set rsp_err=0, rsp_valid=1, go to RESP.
- State ILLEGAL (cycle N+1):
  - The ALU output is not sampled.
  - At edge N+1: rsp_result=0, rsp_zero=1, rsp_sign=0, rsp_err=1, rsp_valid=1, go to RESP.
- Unsupported opcodes: 4, 8, 9 (SGT/SLT/SGE produce no defined result) and 12..15.
- State RESP:
  - rsp_* are held stable and req_ready = 0 while rsp_ready=0.
  - On rsp_valid&rsp_ready: rsp_valid=0 at that edge, go to IDLE.
  - The next grant occurs no earlier than the following cycle.
- Latency and throughput:
  - rsp_valid rises 2 cycles after the request handshake.
  - Peak throughput is 1 operation per 3 cycles.
- alu_* registers hold their last issued values between operations and are not cleared.
- Requests are not stored: a requester keeps req_valid and payload stable until req_ready.
- A requester dropping req_valid before grant is legal and loses nothing.
- DIV by zero is issued normally; the ALU returns 0, so rsp_zero=1 and rsp_err=0.
- Flags are passed through only; carry/overflow are not consumed.

Decomposition:
- Shared package alu_sched_pkg:
  - Opcode localparams DIV=0, SRA=1, ROR=2, ROL=3, SGT=4, OR=5, AND=6, MAX=7, SLT=8, SGE=9, NAND=10, SLL=11.
  - State encoding IDLE/EXEC/ILLEGAL/RESP.
  - Function is_supported(opcode).
- Sub-module rr_arbiter (NUM_REQ):
  - Inputs: req vector, pointer, enable.
  - Outputs: one-hot grant and grant index.
  - Purely combinational; the pointer register lives in the parent.

Test Plan:
- Single op: req0 OR in1=0x00F0 in2=0x0F00 -> rsp_valid 2 cycles later, rsp_result=0x0FF0, zero=0, sign=0, id=0, err=0.
- All four valid continuously, ADD-free ops (AND 0xFFFF&i), rsp_ready=1 -> grants in order 0,1,2,3,0, each response id matches, a new response every 3 cycles.
- Backpressure: SLL in1=0x0001 shift=15 -> result 0x8000, sign=1; hold rsp_ready=0 for 5 cycles -> rsp_* stable, req_ready all 0, grant only after acceptance.
- Unsupported: req2 opcode 4 -> rsp_err=1, rsp_result=0, rsp_zero=1, id=2; opcode 13 gives the same response.
- DIV in1=0x1234 in2=0 -> rsp_result=0, zero=1, err=0; then SRA in1=0x8000 shift=4 -> 0xF800, sign=1.
- rst asserted for 1 cycle during EXEC -> next cycle rsp_valid=0, state IDLE, pointer 0; a pending req1 with req0 also valid -> req0 granted first.
